// File: rtl/chan_pkg.sv
// rtl/chan_pkg.sv - shared types and helpers for the 1-of-N channel source
package chan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_READY,
        ST_DRIVE,
        ST_WAIT_ACK,
        ST_NEUTRAL
    } state_t;

    // Level of the synchronised enable that means "receiver ready"
    localparam bit ENABLE_SENSE = 1'b1;
    localparam bit ACK_SENSE    = 1'b0;

    // Ceiling log2, never less than 1 so a field always has at least one bit
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v * 2;
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Extract digit k of width dbits from a packed table word
    function automatic int unsigned digit_at(input logic [31:0] word,
                                             input int unsigned k,
                                             input int unsigned dbits);
        logic [31:0] mask;
        mask = (32'd1 << dbits) - 32'd1;
        return (word >> (k * dbits)) & mask;
    endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser with selectable reset value
module sync2 #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of an asynchronous level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/chan_1ofn_source.sv
// rtl/chan_1ofn_source.sv - table-driven M-digit 1-of-N four-phase channel source
module chan_1ofn_source
    import chan_pkg::*;
#(
    parameter int RADIX              = 2,
    parameter int DIGITS             = 1,
    parameter int DEPTH              = 16,
    parameter bit ENABLE_ACTIVE_HIGH = 1'b1,
    localparam int DBITS = clog2(RADIX),
    localparam int DW    = DIGITS * DBITS,
    localparam int AW    = clog2(DEPTH),
    localparam int RW    = DIGITS * RADIX
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tbl_we,
    input  logic [AW-1:0] tbl_addr,
    input  logic [DW-1:0] tbl_wdata,
    input  logic [AW:0]   tbl_count,
    input  logic          loop_mode,
    input  logic          start,
    input  logic          release_n,
    input  logic          e_in,
    output logic [RW-1:0] d_out,
    output logic          busy,
    output logic          done,
    output logic          bad_value,
    output logic [15:0]   tok_count
);

    localparam bit READY_LEVEL = ENABLE_ACTIVE_HIGH ? ENABLE_SENSE : ACK_SENSE;
    localparam logic [RW-1:0] RAIL_ONE = {{(RW-1){1'b0}}, 1'b1};

    logic          rst_sync_n;
    logic          e_sync;
    logic          e_rdy;
    state_t        state;
    logic [AW-1:0] ptr;
    logic [AW:0]   count;
    logic [DW-1:0] tbl [DEPTH];
    logic [DW-1:0] rd_word;
    logic [RW-1:0] rails;
    logic          rd_bad;
    int unsigned   dig;
    logic          last;
    logic          fin;
    logic [AW-1:0] nxt_ptr;

    // Reset asserts immediately but releases on a clock edge
    sync2 #(.RESET_VAL(1'b0)) u_rst_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (1'b1),
        .q     (rst_sync_n)
    );

    // Receiver enable resets to the not-ready level for either sense
    sync2 #(.RESET_VAL(~READY_LEVEL)) u_e_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (e_in),
        .q     (e_sync)
    );

    assign e_rdy = (e_sync == READY_LEVEL);

    // Value table: no reset, writable at any time; reads see the pre-write value
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl[tbl_addr] <= tbl_wdata;
        end
    end

    assign rd_word = tbl[ptr];

    // Decode the current entry into one asserted rail per digit
    always_comb begin
        rails  = '0;
        rd_bad = 1'b0;
        dig    = 0;
        for (int k = 0; k < DIGITS; k++) begin
            dig = digit_at(32'(rd_word), k, DBITS);
            if (dig >= RADIX) begin
                rd_bad = 1'b1;
            end else begin
                rails = rails | (RAIL_ONE << (k * RADIX + int'(dig)));
            end
        end
    end

    // Pointer advance shared by the skip and the normal completion paths
    always_comb begin
        last    = ({1'b0, ptr} == (count - 1'b1));
        fin     = last && !loop_mode;
        nxt_ptr = last ? '0 : ptr + 1'b1;
    end

    // Handshake sequencer; rails and status only ever change from here
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            count     <= '0;
            d_out     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bad_value <= 1'b0;
            tok_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (tbl_count != '0) begin
                            ptr   <= '0;
                            count <= tbl_count;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            state <= ST_WAIT_READY;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_WAIT_READY: begin
                    d_out <= '0;
                    if (e_rdy && release_n) begin
                        state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (rd_bad) begin
                        bad_value <= 1'b1;
                        ptr       <= nxt_ptr;
                        if (fin) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_WAIT_READY;
                        end
                    end else begin
                        d_out <= rails;
                        state <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (!e_rdy) begin
                        state <= ST_NEUTRAL;
                    end
                end
                ST_NEUTRAL: begin
                    d_out     <= '0;
                    tok_count <= tok_count + 16'd1;
                    ptr       <= nxt_ptr;
                    if (fin) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_WAIT_READY;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chan_1ofn_source.sv
// tb/tb_chan_1ofn_source.sv - scoreboard bench for chan_1ofn_source (RADIX=3, DIGITS=2, ack sense)
module tb_chan_1ofn_source;

    localparam int RX_DELAY = 3;

    logic        clk;
    logic        rst_n;
    logic        tbl_we;
    logic [3:0]  tbl_addr;
    logic [3:0]  tbl_wdata;
    logic [4:0]  tbl_count;
    logic        loop_mode;
    logic        start;
    logic        release_n;
    logic        e_in;
    logic [5:0]  d_out;
    logic        busy;
    logic        done;
    logic        bad_value;
    logic [15:0] tok_count;

    logic        rx_en;
    logic [5:0]  exp_q[$];
    int          total;
    int          bad;

    chan_1ofn_source #(
        .RADIX              (3),
        .DIGITS             (2),
        .DEPTH              (16),
        .ENABLE_ACTIVE_HIGH (1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_wdata (tbl_wdata),
        .tbl_count (tbl_count),
        .loop_mode (loop_mode),
        .start     (start),
        .release_n (release_n),
        .e_in      (e_in),
        .d_out     (d_out),
        .busy      (busy),
        .done      (done),
        .bad_value (bad_value),
        .tok_count (tok_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        @(negedge clk);
        tbl_we    = 1'b1;
        tbl_addr  = a;
        tbl_wdata = d;
        @(negedge clk);
        tbl_we    = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", done, 1);
    endtask

    // Receiver: ack (e high) some cycles after valid data, release after neutral
    initial begin
        int   cnt;
        logic tgt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (rx_en) begin
                tgt = (d_out != '0);
                if (e_in != tgt) begin
                    cnt++;
                    if (cnt >= RX_DELAY) begin
                        e_in = tgt;
                        cnt  = 0;
                    end
                end else begin
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: every new token is compared against the scoreboard, then held-stable is checked
    initial begin
        logic [5:0] held;
        logic       active;
        logic       unstable;
        active   = 1'b0;
        unstable = 1'b0;
        held     = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0;
            end else if (!active && d_out != '0) begin
                active   = 1'b1;
                held     = d_out;
                unstable = 1'b0;
                if (exp_q.size() == 0) begin
                    check("token_unexpected", d_out, 0);
                end else begin
                    check("token_rails", d_out, exp_q.pop_front());
                end
            end else if (active && d_out == '0) begin
                active = 1'b0;
                check("rails_stable", unstable, 0);
            end else if (active && d_out != held) begin
                unstable = 1'b1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        tbl_we    = 1'b0;
        tbl_addr  = '0;
        tbl_wdata = '0;
        tbl_count = '0;
        loop_mode = 1'b0;
        start     = 1'b0;
        release_n = 1'b1;
        e_in      = 1'b1;
        rx_en     = 1'b0;

        cycles(4);
        check("rst_d_out", d_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bad_value", bad_value, 0);
        check("rst_tok_count", tok_count, 0);
        rst_n = 1'b1;
        cycles(4);

        // Empty table start: immediate done, never busy
        tbl_count = 5'd0;
        pulse_start();
        check("zero_count_done", done, 1);
        check("zero_count_busy", busy, 0);

        // One-shot with a bad entry; first token latency from e_in ready
        wr(4'd0, 4'h9);
        wr(4'd1, 4'h6);
        wr(4'd2, 4'h0);
        wr(4'd3, 4'h3);
        wr(4'd4, 4'hA);
        tbl_count = 5'd5;
        loop_mode = 1'b0;
        exp_q.push_back(6'b100_010);
        exp_q.push_back(6'b010_100);
        exp_q.push_back(6'b001_001);
        exp_q.push_back(6'b100_100);
        pulse_start();
        cycles(3);
        check("t1_busy", busy, 1);
        check("t1_done_cleared", done, 0);
        check("t1_neutral_wait", d_out, 0);
        e_in = 1'b0;
        lat  = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (d_out == '0 && lat < 20);
        check("t1_latency", lat, 4);
        rx_en = 1'b1;
        wait_done(1000);
        check("t1_tok_count", tok_count, 4);
        check("t1_bad_value", bad_value, 1);
        check("t1_busy_end", busy, 0);
        check("t1_q_empty", exp_q.size(), 0);

        // Loop mode: 10 tokens of {0,1,1}, pause, then clear loop to end the pass
        wr(4'd0, 4'h0);
        wr(4'd1, 4'h9);
        wr(4'd2, 4'h9);
        tbl_count = 5'd3;
        loop_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back((i % 3 == 0) ? 6'b001_001 : 6'b100_010);
        end
        pulse_start();
        n = 0;
        while (tok_count != 16'd14 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        rx_en = 1'b0;
        cycles(10);
        check("t2_tok_count", tok_count, 14);
        check("t2_done_low", done, 0);
        check("t2_busy", busy, 1);
        check("t2_q_empty", exp_q.size(), 0);
        loop_mode = 1'b0;
        exp_q.push_back(6'b100_010);
        exp_q.push_back(6'b100_010);
        rx_en = 1'b1;
        wait_done(1000);
        check("t2_tok_final", tok_count, 16);
        check("t2_q_empty_end", exp_q.size(), 0);

        // Channel held neutral by release_n
        release_n = 1'b0;
        pulse_start();
        cycles(10);
        check("t3_hold_d_out", d_out, 0);
        check("t3_hold_busy", busy, 1);
        check("t3_hold_tok", tok_count, 16);
        exp_q.push_back(6'b001_001);
        exp_q.push_back(6'b100_010);
        exp_q.push_back(6'b100_010);
        release_n = 1'b1;
        wait_done(1000);
        check("t3_tok_count", tok_count, 19);
        check("t3_q_empty", exp_q.size(), 0);

        // Reset while data is on the rails, then restart from entry 0
        exp_q.push_back(6'b001_001);
        pulse_start();
        n = 0;
        while (d_out == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t4_async_d_out", d_out, 0);
        check("t4_busy", busy, 0);
        check("t4_done", done, 0);
        check("t4_bad_value", bad_value, 0);
        check("t4_tok_count", tok_count, 0);
        exp_q.delete();
        cycles(3);
        rst_n = 1'b1;
        cycles(4);
        exp_q.push_back(6'b001_001);
        exp_q.push_back(6'b100_010);
        exp_q.push_back(6'b100_010);
        pulse_start();
        wait_done(1000);
        check("t4_restart_tok", tok_count, 3);
        check("t4_restart_bad", bad_value, 0);
        check("t4_q_empty", exp_q.size(), 0);

        cycles(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
